chip8: RTL and testbench
========================

CHIP8 -- requirements
Module: chip8

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; bit period CLK_HZ/BAUD = 434 clocks, integer-truncated.
REQ-003 Parameter FRAME_HZ, default 60, frame tick rate; tick period CLK_HZ/FRAME_HZ = 833333 clocks.
REQ-004 Parameter ROM_FILE, default "rom.hex", hex image loaded into memory at 0x200 at elaboration.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 uart_tx  output  1  serial status output: 8N1, LSB first, idle high.

Function
REQ-008 The core SHALL have:
- 4096x8 memory; PC and I 12-bit.
- V0..VF 8-bit registers.
- 16x12-bit stack with 4-bit SP.
- 8-bit delay timer DT.
REQ-009 The CPU FSM SHALL cycle FETCH_HI -> FETCH_LO -> EXEC -> FETCH_HI, one instruction per 3 clocks.
REQ-010 In EXEC, PC SHALL advance by 2 unless the instruction writes PC; a taken skip SHALL add 4; PC wraps modulo 4096.
REQ-011 Supported opcodes:
- 00EE return; 1NNN jump; 2NNN call.
- 3XNN/4XNN/5XY0/9XY0 skip-if-equal / not-equal.
- 6XNN load; 7XNN add without flag.
- 8XY0/1/2/3 move/or/and/xor.
- 8XY4 add, VF = carry.
- 8XY5 VX-VY, VF = not-borrow.
- ANNN I=NNN.
- FX07 VX=DT; FX15 DT=VX; FX1E I=I+VX modulo 4096.
REQ-012 For 8XY4/8XY5, VF SHALL be written after the result, so X=F yields the flag.
REQ-013 Every other opcode SHALL be a no-op that advances PC by 2.
REQ-014 SP SHALL wrap modulo 16 on call overflow and on return underflow, with no error indication.
REQ-015 A frame tick SHALL pulse for one clock when the frame counter is 0; the counter counts 0..833332 and wraps.
REQ-016 On each tick, DT SHALL decrement if nonzero; an FX15 in the same cycle SHALL take priority.
REQ-017 On each tick, if the transmitter is idle, the block SHALL snapshot PC and V0 as they are before that cycle's update.
REQ-018 It SHALL then send 4 bytes: 0xC8, {4'h0, PC[11:8]}, PC[7:0], V0.
REQ-019 A tick arriving while a frame is still being sent SHALL be dropped.
REQ-020 Each byte SHALL be sent as a start bit (0), 8 data bits LSB first, then a stop bit (1), each bit lasting 434 clocks.
REQ-021 Consecutive bytes of one frame SHALL be sent back-to-back with no idle gap.

Reset
REQ-022 While rst=1, the block SHALL hold:
- uart_tx=1, PC=0x200.
- I=0, SP=0, DT=0, V0..VF=0.
- FSM=FETCH_HI, frame counter=0, transmitter idle.
REQ-023 Memory contents SHALL NOT be affected by reset.
REQ-024 Reset asserted mid-instruction or mid-byte SHALL abort the operation immediately, with no further output bits.
REQ-025 The first tick SHALL occur in the first clock after rst deasserts, so the first frame starts at once.

Structure
REQ-026 Package chip8_pkg SHALL hold:
- FSM state enum.
- Opcode nibble constants.
- Start address 0x200.
- Frame header 0xC8.
REQ-027 A sub-module chip8_uart_tx SHALL implement the byte serializer, with inputs data/valid and output busy.
REQ-028 The top SHALL contain the CPU, memory, timer and frame sequencer, in 120-400 lines total.

Verification
REQ-029 Reset test: rst=1 for 5 clocks -> uart_tx=1 throughout; start bit falls 1 clock after release.
REQ-030 Status frame test: ROM 6042 1202 ->
- Frame 1 decodes C8 02 00 00.
- Frame 2, 833333 clocks later, decodes C8 02 02 42.
REQ-031 Bit timing test: byte 0xC8 -> line levels 0,0,0,0,1,0,0,1,1,1, each exactly 434 clocks.
REQ-032 Carry test: ROM 60FF 6101 8014 80F0 1208 -> frame 2 decodes C8 02 08 01.
REQ-033 Call/return test: ROM 2206 6055 1204 6033 00EE -> frame 2 decodes C8 02 04 55.
REQ-034 Delay-timer test: ROM 6003 F015 F007 1206 with DT=3 -> frame 2 shows V0=03.

Source files
------------

// File: rtl/chip8_pkg.sv
// chip8_pkg: CPU states, opcode nibbles and status-frame constants shared by the chip8 core.
package chip8_pkg;
  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, EXEC} cpu_state_t;
  localparam logic [11:0] START_ADDR = 12'h200;
  localparam logic [7:0] FRAME_HDR = 8'hC8;
  localparam logic [3:0] OP_SYS = 4'h0;
  localparam logic [3:0] OP_JP = 4'h1;
  localparam logic [3:0] OP_CALL = 4'h2;
  localparam logic [3:0] OP_SE_NN = 4'h3;
  localparam logic [3:0] OP_SNE_NN = 4'h4;
  localparam logic [3:0] OP_SE_XY = 4'h5;
  localparam logic [3:0] OP_LD_NN = 4'h6;
  localparam logic [3:0] OP_ADD_NN = 4'h7;
  localparam logic [3:0] OP_ALU = 4'h8;
  localparam logic [3:0] OP_SNE_XY = 4'h9;
  localparam logic [3:0] OP_LD_I = 4'hA;
  localparam logic [3:0] OP_MISC = 4'hF;
endpackage

// File: rtl/chip8_if.sv
// chip8_if: byte handshake between the status-frame sequencer and the UART serializer.
interface chip8_if;
  logic [7:0] data;
  logic valid;
  logic busy;
  modport master (output data, valid, input busy);
  modport slave (input data, valid, output busy);
endinterface

// File: rtl/chip8_uart_tx.sv
// chip8_uart_tx: 8N1 serializer, LSB first; drops busy in the last stop-bit clock so bytes chain gap-free.
module chip8_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic clk,
  input logic rst,
  chip8_if.slave tx_if,
  output logic uart_tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [8:0] shift;
  logic active;
  logic bit_end;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_if.busy = active && !(bit_end && bit_idx == 4'd9);
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      uart_tx <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '1;
    end else if (tx_if.valid && !tx_if.busy) begin
      active <= 1'b1;
      uart_tx <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      shift <= {1'b1, tx_if.data};
    end else if (active) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (bit_end) begin
        // shift fills with ones, so the bit after d7 is the stop bit and then idle
        bit_idx <= bit_idx + 4'd1;
        uart_tx <= shift[0];
        shift <= {1'b1, shift[8:1]};
        active <= bit_idx != 4'd9;
      end
    end
  end
endmodule

// File: rtl/chip8.sv
// chip8: CHIP-8 subset core (3 clocks per instruction) with delay timer and a per-frame
// UART status stream of {C8, PC[11:8], PC[7:0], V0}.
module chip8
  import chip8_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int FRAME_HZ = 60,
  parameter string ROM_FILE = "rom.hex"
) (
  input logic clk,
  input logic rst,
  output logic uart_tx
);
  localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;
  localparam int FW = $clog2(FRAME_DIV);
  logic [7:0] mem [4096];
  logic [7:0] v [16];
  logic [11:0] stack [16];
  logic [11:0] pc, i_reg, pc_nxt;
  logic [3:0] sp;
  logic [7:0] dt;
  logic [15:0] ir;
  cpu_state_t state, state_nxt;
  logic [FW-1:0] frame_cnt;
  logic tick;
  logic [3:0] op, x, y, n;
  logic [7:0] nn, vx, vy, x_val;
  logic [8:0] sum;
  logic wr_x, wr_f, f_val, is_ret, skip;
  logic sending, start;
  logic [1:0] byte_idx;
  logic [11:0] snap_pc;
  logic [7:0] snap_v0;
  chip8_if tx_if ();
  assign {op, x, y, n} = ir;
  assign nn = ir[7:0];
  assign vx = v[x];
  assign vy = v[y];
  assign tick = frame_cnt == '0;
  always_comb begin
    state_nxt = state == FETCH_HI ? FETCH_LO : state == FETCH_LO ? EXEC : FETCH_HI;
    is_ret = op == OP_SYS && ir[11:0] == 12'h0EE;
    skip = (op == OP_SE_NN && vx == nn) || (op == OP_SNE_NN && vx != nn) ||
           (op == OP_SE_XY && n == 4'h0 && vx == vy) || (op == OP_SNE_XY && n == 4'h0 && vx != vy);
    pc_nxt = (op == OP_JP || op == OP_CALL) ? ir[11:0] : is_ret ? stack[sp - 4'd1] : pc + (skip ? 12'd4 : 12'd2);
    sum = {1'b0, vx} + {1'b0, vy};
    wr_x = 1'b0;
    wr_f = 1'b0;
    x_val = nn;
    f_val = 1'b0;
    case (op)
      OP_LD_NN: wr_x = 1'b1;
      OP_ADD_NN: begin
        wr_x = 1'b1;
        x_val = vx + nn;
      end
      OP_ALU: begin
        wr_x = n <= 4'h5;
        wr_f = n == 4'h4 || n == 4'h5;
        x_val = n == 4'h0 ? vy : n == 4'h1 ? vx | vy : n == 4'h2 ? vx & vy :
                n == 4'h3 ? vx ^ vy : n == 4'h4 ? sum[7:0] : vx - vy;
        f_val = n == 4'h4 ? sum[8] : vx >= vy;
      end
      OP_MISC: begin
        wr_x = nn == 8'h07;
        x_val = dt;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? FETCH_HI : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= START_ADDR;
      i_reg <= '0;
      sp <= '0;
      dt <= '0;
      ir <= '0;
      for (int k = 0; k < 16; k++) v[k] <= '0;
    end else begin
      if (tick && dt != '0) dt <= dt - 8'd1;
      if (state == FETCH_HI) ir[15:8] <= mem[pc];
      if (state == FETCH_LO) ir[7:0] <= mem[pc + 12'd1];
      if (state == EXEC) begin
        pc <= pc_nxt;
        if (op == OP_CALL) begin
          stack[sp] <= pc + 12'd2;
          sp <= sp + 4'd1;
        end
        if (is_ret) sp <= sp - 4'd1;
        if (op == OP_LD_I) i_reg <= ir[11:0];
        if (op == OP_MISC && nn == 8'h1E) i_reg <= i_reg + {4'h0, vx};
        if (op == OP_MISC && nn == 8'h15) dt <= vx;
        if (wr_x) v[x] <= x_val;
        if (wr_f) v[15] <= {7'd0, f_val};
      end
    end
  end
  always_ff @(posedge clk) frame_cnt <= (rst || frame_cnt == FW'(FRAME_DIV - 1)) ? '0 : frame_cnt + 1'b1;
  assign start = tick && !sending && !tx_if.busy;
  assign tx_if.valid = start || sending;
  assign tx_if.data = byte_idx == 2'd1 ? {4'h0, snap_pc[11:8]} : byte_idx == 2'd2 ? snap_pc[7:0] :
                      byte_idx == 2'd3 ? snap_v0 : FRAME_HDR;
  always_ff @(posedge clk) begin
    if (rst) begin
      sending <= 1'b0;
      byte_idx <= '0;
      snap_pc <= '0;
      snap_v0 <= '0;
    end else if (start) begin
      sending <= 1'b1;
      byte_idx <= 2'd1;
      snap_pc <= pc;
      snap_v0 <= v[0];
    end else if (sending && !tx_if.busy) begin
      byte_idx <= byte_idx + 2'd1;
      sending <= byte_idx != 2'd3;
    end
  end
  chip8_uart_tx #(.CLKS_PER_BIT(CLK_HZ / BAUD)) u_tx (
    .clk(clk),
    .rst(rst),
    .tx_if(tx_if),
    .uart_tx(uart_tx)
  );
endmodule

// File: tb/tb_chip8.sv
// tb_chip8: program vectors decoded from the UART status stream, plus reset, abort,
// dropped-tick and exact bit-timing sequences.
module tb_chip8;
  typedef struct packed {
    logic [79:0] rom;
    logic [3:0] len;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, tx2, bt_tx;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  chip8_if bif ();
  chip8 #(.CLK_HZ(1_000_000), .BAUD(100_000), .FRAME_HZ(1000), .ROM_FILE("")) dut (
    .clk(clk), .rst(rst), .uart_tx(tx));
  chip8 #(.CLK_HZ(1_000_000), .BAUD(50_000), .FRAME_HZ(2000), .ROM_FILE("")) dut2 (
    .clk(clk), .rst(rst), .uart_tx(tx2));
  chip8_uart_tx #(.CLKS_PER_BIT(434)) u_bt (.clk(clk), .rst(rst), .tx_if(bif), .uart_tx(bt_tx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rx_byte(input bit sel, input int cpb, output logic [7:0] b, output int t, output bit ok);
    int cnt;
    cnt = 0;
    ok = 1'b1;
    b = '0;
    t = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while ((sel ? tx2 : tx) !== 1'b0 && cnt < 3000);
    if ((sel ? tx2 : tx) !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t = cyc;
    repeat (cpb / 2) @(negedge clk);
    if ((sel ? tx2 : tx) !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (cpb) @(negedge clk);
      b[k] = sel ? tx2 : tx;
    end
    repeat (cpb) @(negedge clk);
    if ((sel ? tx2 : tx) !== 1'b1) ok = 1'b0;
  endtask
  task automatic rx_frame(input bit sel, input int cpb, output logic [31:0] f, output int t0, output bit ok);
    logic [7:0] b;
    int t, tp;
    bit okb;
    ok = 1'b1;
    f = '0;
    t0 = 0;
    tp = 0;
    for (int k = 0; k < 4; k++) begin
      rx_byte(sel, cpb, b, t, okb);
      if (!okb) begin
        ok = 1'b0;
        return;
      end
      if (k == 0) t0 = t;
      else if (t != tp + 10 * cpb) ok = 1'b0;
      tp = t;
      f = {f[23:0], b};
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t vecs [12];
    logic [15:0] w;
    logic [31:0] f;
    logic [9:0] lv;
    int t0, t1, r, lows, bad;
    bit ok;
    vecs[0] = '{80'h6042_1202_0000_0000_0000, 4'd2, 32'hC802_0242};
    vecs[1] = '{80'h60FF_6101_8014_80F0_1208, 4'd5, 32'hC802_0801};
    vecs[2] = '{80'h2206_6055_1204_6033_00EE, 4'd5, 32'hC802_0455};
    vecs[3] = '{80'h6003_F015_F007_1206_0000, 4'd4, 32'hC802_0603};
    vecs[4] = '{80'h6005_6107_8015_1206_0000, 4'd4, 32'hC802_06FE};
    vecs[5] = '{80'h6011_3011_6022_1206_0000, 4'd4, 32'hC802_0611};
    vecs[6] = '{80'h6F09_6103_8F15_80F0_1208, 4'd5, 32'hC802_0801};
    vecs[7] = '{80'h60F0_613C_8012_8013_1208, 4'd5, 32'hC802_080C};
    vecs[8] = '{80'h6077_E0A1_8016_1206_0000, 4'd4, 32'hC802_0677};
    vecs[9] = '{80'h6001_6102_9010_6099_1208, 4'd5, 32'hC802_0801};
    vecs[10] = '{80'h60F0_7020_1204_0000_0000, 4'd3, 32'hC802_0410};
    vecs[11] = '{80'h6005_4005_6066_1206_0000, 4'd4, 32'hC802_0666};
    bif.valid = 1'b0;
    bif.data = 8'h00;
    for (int k = 0; k < 1024; k++) dut2.mem[12'h200 + 12'(k)] = 8'h00;
    lows = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx2 !== 1'b1 || bt_tx !== 1'b1) lows++;
    end
    chk("reset_idle", lows, 0);
    for (int i = 0; i < 12; i++) begin
      rst = 1'b1;
      for (int k = 0; k < 32; k++) dut.mem[12'h200 + 12'(k)] = 8'h00;
      for (int k = 0; k < int'(vecs[i].len); k++) begin
        w = vecs[i].rom[79 - 16 * k -: 16];
        dut.mem[12'h200 + 12'(2 * k)] = w[15:8];
        dut.mem[12'h201 + 12'(2 * k)] = w[7:0];
      end
      repeat (5) @(negedge clk);
      rst = 1'b0;
      r = cyc;
      rx_frame(1'b0, 10, f, t0, ok);
      chk($sformatf("v%0d_frame1", i), f, 32'hC802_0000);
      chk($sformatf("v%0d_start", i), t0 - r, 1);
      chk($sformatf("v%0d_format1", i), 32'(ok), 1);
      rx_frame(1'b0, 10, f, t1, ok);
      chk($sformatf("v%0d_frame2", i), f, vecs[i].exp);
      chk($sformatf("v%0d_period", i), t1 - t0, 1000);
      chk($sformatf("v%0d_format2", i), 32'(ok), 1);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_pre_level", 32'(tx), 0);
    rst = 1'b1;
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("abort_idle", lows, 0);
    rst = 1'b0;
    r = cyc;
    rx_frame(1'b0, 10, f, t0, ok);
    chk("abort_restart_frame", f, 32'hC802_0000);
    chk("abort_restart_start", t0 - r, 1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    rx_frame(1'b1, 20, f, t0, ok);
    chk("drop_frame1", f, 32'hC802_0000);
    chk("drop_start", t0 - r, 1);
    rx_frame(1'b1, 20, f, t1, ok);
    chk("drop_frame2", f, 32'hC804_9A00);
    chk("drop_period", t1 - t0, 1000);
    chk("drop_format", 32'(ok), 1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    lv = 10'b1110010000;
    bif.data = 8'hC8;
    bif.valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < 434; c++) begin
        @(negedge clk);
        bif.valid = 1'b0;
        if (bt_tx !== lv[k]) bad++;
      end
      chk($sformatf("bit%0d_level", k), bad, 0);
    end
    @(negedge clk);
    chk("bit_idle", 32'({bt_tx, bif.busy}), 32'h2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
